// File: rtl/rprelu_para_loader.sv
// RPReLU parameter loader: deserialises beta/gamma/zeta banks from a word stream.
// Optional PARA_LOAD_CHECKSUM_EN appends a mod-2^PARA_WIDTH checksum word.
`ifndef PARA_WIDTH
`define PARA_WIDTH 16
`endif

module rprelu_para_loader #(
  parameter int CHANNEL_NUM = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          mode,
  input  logic signed [`PARA_WIDTH-1:0] para_in,
  input  logic                          para_valid,
  output logic                          para_ready,
  output logic signed [`PARA_WIDTH-1:0] rprelu_beta  [CHANNEL_NUM-1:0],
  output logic signed [`PARA_WIDTH-1:0] rprelu_gamma [CHANNEL_NUM-1:0],
  output logic signed [`PARA_WIDTH-1:0] rprelu_zeta  [CHANNEL_NUM-1:0],
  output logic                          load_done,
  output logic                          load_abort,
  output logic                          load_err
);

  localparam int W  = `PARA_WIDTH;
  localparam int CW = $clog2(CHANNEL_NUM);
  localparam logic [CW-1:0] LAST = CW'(CHANNEL_NUM - 1);

`ifdef PARA_LOAD_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, LD_BETA, LD_GAMMA, LD_ZETA, LD_CSUM, DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, LD_BETA, LD_GAMMA, LD_ZETA, DONE
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          abort_q, abort_d;
  logic          wr_beta, wr_gamma, wr_zeta;
  logic          xfer, last;

  logic signed [W-1:0] beta_q  [CHANNEL_NUM-1:0];
  logic signed [W-1:0] gamma_q [CHANNEL_NUM-1:0];
  logic signed [W-1:0] zeta_q  [CHANNEL_NUM-1:0];

`ifdef PARA_LOAD_CHECKSUM_EN
  logic [W-1:0] sum_q, sum_d;
  logic         err_q, err_d;
`endif

  assign xfer = para_valid && para_ready;
  assign last = (cnt_q == LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    abort_d    = 1'b0;
    para_ready = 1'b0;
    wr_beta    = 1'b0;
    wr_gamma   = 1'b0;
    wr_zeta    = 1'b0;
`ifdef PARA_LOAD_CHECKSUM_EN
    sum_d      = sum_q;
    err_d      = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!mode) begin
          state_d = LD_BETA;
          cnt_d   = '0;
          done_d  = 1'b0;
`ifdef PARA_LOAD_CHECKSUM_EN
          sum_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      LD_BETA, LD_GAMMA, LD_ZETA: begin
        para_ready = !mode;
        if (mode) begin
          state_d = IDLE;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (xfer) begin
          cnt_d = last ? '0 : cnt_q + 1'b1;
`ifdef PARA_LOAD_CHECKSUM_EN
          sum_d = sum_q + para_in;
`endif
          unique case (state_q)
            LD_BETA: begin
              wr_beta = 1'b1;
              if (last) state_d = LD_GAMMA;
            end
            LD_GAMMA: begin
              wr_gamma = 1'b1;
              if (last) state_d = LD_ZETA;
            end
            default: begin
              wr_zeta = 1'b1;
              if (last) begin
`ifdef PARA_LOAD_CHECKSUM_EN
                state_d = LD_CSUM;
`else
                state_d = DONE;
                done_d  = 1'b1;
`endif
              end
            end
          endcase
        end
      end
`ifdef PARA_LOAD_CHECKSUM_EN
      LD_CSUM: begin
        para_ready = !mode;
        if (mode) begin
          state_d = IDLE;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (xfer) begin
          state_d = DONE;
          done_d  = (para_in == sum_q);
          err_d   = (para_in != sum_q);
        end
      end
`endif
      DONE: begin
        if (mode) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
`ifdef PARA_LOAD_CHECKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      abort_q <= abort_d;
`ifdef PARA_LOAD_CHECKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

  // Banks only change on an accepted word; partial loads are kept on abort.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNEL_NUM; i++) begin
        beta_q[i]  <= '0;
        gamma_q[i] <= '0;
        zeta_q[i]  <= '0;
      end
    end else begin
      if (wr_beta)  beta_q[cnt_q]  <= para_in;
      if (wr_gamma) gamma_q[cnt_q] <= para_in;
      if (wr_zeta)  zeta_q[cnt_q]  <= para_in;
    end
  end

  assign rprelu_beta  = beta_q;
  assign rprelu_gamma = gamma_q;
  assign rprelu_zeta  = zeta_q;
  assign load_done    = done_q;
  assign load_abort   = abort_q;

`ifdef PARA_LOAD_CHECKSUM_EN
  assign load_err = err_q;
`else
  assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_rprelu_para_loader.sv
// Self-checking bench for rprelu_para_loader (CHANNEL_NUM=4).
// Word-indexed reference model; checksum cases run under PARA_LOAD_CHECKSUM_EN.
`ifndef PARA_WIDTH
`define PARA_WIDTH 16
`endif

module tb_rprelu_para_loader;

  localparam int N = 4;
  localparam int W = `PARA_WIDTH;
`ifdef PARA_LOAD_CHECKSUM_EN
  localparam int NW = 3*N + 1;
`else
  localparam int NW = 3*N;
`endif

  logic clk = 1'b0;
  logic rst_n, mode, para_valid, para_ready;
  logic signed [W-1:0] para_in;
  logic signed [W-1:0] beta  [N-1:0];
  logic signed [W-1:0] gamma [N-1:0];
  logic signed [W-1:0] zeta  [N-1:0];
  logic load_done, load_abort, load_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rprelu_para_loader #(.CHANNEL_NUM(N)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .para_in(para_in), .para_valid(para_valid),
    .para_ready(para_ready),
    .rprelu_beta(beta), .rprelu_gamma(gamma),
    .rprelu_zeta(zeta),
    .load_done(load_done), .load_abort(load_abort),
    .load_err(load_err)
  );

  typedef enum {P_IDLE, P_LOAD, P_DONE} ph_t;
  ph_t          ph;
  int           k;
  logic [W-1:0] bank [3][N];
  logic [W-1:0] sum;
  logic         e_done, e_abort, e_err;
  logic         last_xfer;
  logic [W-1:0] words [NW];

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: word k of a load lands in bank k/N, channel k%N.
  task automatic model_edge();
    e_abort = 1'b0;
    if (!rst_n) begin
      ph = P_IDLE; k = 0; sum = '0;
      e_done = 1'b0; e_err = 1'b0;
      for (int b = 0; b < 3; b++)
        for (int c = 0; c < N; c++) bank[b][c] = '0;
    end else begin
      case (ph)
        P_IDLE: if (!mode) begin
          ph = P_LOAD; k = 0; sum = '0;
          e_done = 1'b0; e_err = 1'b0;
        end
        P_LOAD: begin
          if (mode) begin
            ph = P_IDLE; e_abort = 1'b1;
          end else if (para_valid) begin
            if (k < 3*N) begin
              bank[k/N][k%N] = para_in;
              sum = sum + para_in;
              k++;
              if (k == NW) begin
                ph = P_DONE; e_done = 1'b1;
              end
            end else begin
              ph = P_DONE;
              e_done = (para_in == sum);
              e_err  = (para_in != sum);
            end
          end
        end
        default: if (mode) ph = P_IDLE;
      endcase
    end
  endtask

  task automatic cycle(input logic r, input logic m,
                       input logic v, input logic [W-1:0] d);
    rst_n = r; mode = m; para_valid = v; para_in = d;
    #1;
    last_xfer = (ph == P_LOAD) && !m && v && r;
    chk("para_ready", para_ready, W'(ph == P_LOAD && !m));
    @(posedge clk); #1;
    model_edge();
    chk("load_done", load_done, W'(e_done));
    chk("load_abort", load_abort, W'(e_abort));
    chk("load_err", load_err, W'(e_err));
    for (int c = 0; c < N; c++) begin
      chk($sformatf("beta[%0d]", c), beta[c], bank[0][c]);
      chk($sformatf("gamma[%0d]", c), gamma[c], bank[1][c]);
      chk($sformatf("zeta[%0d]", c), zeta[c], bank[2][c]);
    end
  endtask

  task automatic load_stream(input int nw, input bit toggle,
                             output int rdy_n, output int ld_n);
    int idx;
    int guard;
    logic v;
    idx = 0; guard = 0; rdy_n = 0; ld_n = 0;
    while (idx < nw && guard < 200) begin
      v = !toggle || ((ld_n % 2) == 0);
      if (ph == P_LOAD) begin
        ld_n++;
        rdy_n++;
      end
      cycle(1'b1, 1'b0, v, words[idx]);
      if (last_xfer) idx++;
      guard++;
    end
    if (guard >= 200) chk("stream_timeout", W'(0), W'(1));
  endtask

  task automatic fill_base();
    logic [W-1:0] s;
    s = '0;
    for (int c = 0; c < N; c++) begin
      words[c]       = W'(16'h0001 + c);
      words[N + c]   = W'(16'h0010 + c);
      words[2*N + c] = W'(16'hFFF0 + c);
    end
    for (int i = 0; i < 3*N; i++) s = s + words[i];
    if (NW > 3*N) words[NW-1] = s;
  endtask

  int rdy, ld;
  logic rm;

  initial begin
    rst_n = 1'b0; mode = 1'b1; para_valid = 1'b0; para_in = '0;
    @(posedge clk); #1;
    model_edge();
    cycle(1'b0, 1'b1, 1'b0, '0);
    chk("rst_done", load_done, '0);
    chk("rst_beta0", beta[0], '0);

    // Scenario 1: valid held high.
    fill_base();
    load_stream(NW, 1'b0, rdy, ld);
    chk("s1_ready_cycles", W'(rdy), W'(NW));
    chk("s1_beta3", beta[3], 16'h0004);
    chk("s1_gamma0", gamma[0], 16'h0010);
    chk("s1_zeta2", zeta[2], 16'hFFF2);
    chk("s1_done", load_done, W'(1));
    cycle(1'b1, 1'b0, 1'b1, 16'h1234);
    cycle(1'b1, 1'b1, 1'b0, '0);

    // Scenario 2: valid toggling.
    load_stream(NW, 1'b1, rdy, ld);
    chk("s2_ld_cycles", W'(ld), W'(2*NW - 1));
    chk("s2_beta3", beta[3], 16'h0004);
    chk("s2_zeta2", zeta[2], 16'hFFF2);
    chk("s2_done", load_done, W'(1));
    cycle(1'b1, 1'b1, 1'b0, '0);

    // Scenario 3: abort after 6 transfers.
    for (int i = 0; i < 3*N; i++) words[i] = W'($urandom);
    load_stream(6, 1'b0, rdy, ld);
    cycle(1'b1, 1'b1, 1'b1, 16'h7777);
    chk("s3_abort", load_abort, W'(1));
    chk("s3_done", load_done, '0);
    chk("s3_gamma1", gamma[1], words[5]);
    chk("s3_gamma2", gamma[2], 16'h0012);
    chk("s3_gamma3", gamma[3], 16'h0013);
    cycle(1'b1, 1'b1, 1'b0, '0);
    chk("s3_abort_once", load_abort, '0);
    fill_base();
    load_stream(NW, 1'b0, rdy, ld);
    chk("s3_restart_beta0", beta[0], 16'h0001);
    chk("s3_restart_done", load_done, W'(1));

    // Scenario 4: calculate mode blocks writes.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b1, 16'h7FFF);
    chk("s4_done", load_done, W'(1));
    chk("s4_beta0", beta[0], 16'h0001);

    // Scenario 5: reset mid-load.
    load_stream(5, 1'b0, rdy, ld);
    cycle(1'b0, 1'b0, 1'b1, 16'h5555);
    chk("s5_beta0", beta[0], '0);
    chk("s5_gamma0", gamma[0], '0);
    chk("s5_done", load_done, '0);
    load_stream(NW, 1'b0, rdy, ld);
    chk("s5_reload_done", load_done, W'(1));
    chk("s5_reload_zeta3", zeta[3], 16'hFFF3);

`ifdef PARA_LOAD_CHECKSUM_EN
    // Scenario 6: checksum pass then mismatch.
    cycle(1'b1, 1'b1, 1'b0, '0);
    load_stream(NW, 1'b0, rdy, ld);
    chk("s6_done_ok", load_done, W'(1));
    chk("s6_err_ok", load_err, '0);
    cycle(1'b1, 1'b1, 1'b0, '0);
    words[NW-1] = words[NW-1] + 1'b1;
    load_stream(NW, 1'b0, rdy, ld);
    chk("s6_done_bad", load_done, '0);
    chk("s6_err_bad", load_err, W'(1));
    chk("s6_beta3_kept", beta[3], 16'h0004);
`endif

    // Random traffic against the model.
    rm = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (rm ? ($urandom_range(0, 7) == 0)
             : ($urandom_range(0, 29) == 0)) rm = ~rm;
      cycle($urandom_range(0, 99) != 0, rm,
            $urandom_range(0, 3) != 0, W'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rprelu_para_loader.md
Name: rprelu_para_loader

Overview:
- Parameter-side producer for the RPReLU stage. Receives a serial word stream from the off-layer parameter bus while `mode` is LOW (reload).
- Deserialises the stream into per-channel register banks `rprelu_beta`, `rprelu_gamma` and `rprelu_zeta`.
- Holds those banks stable while `mode` is HIGH (calculate), which is when the RPReLU datapath consumes them.
- Flags completion (`load_done`) and aborted loads (`load_abort`) to the layer controller.

Parameters:
- CHANNEL_NUM, 256: number of channels per bank. Must be at least 2. The channel counter is $clog2(CHANNEL_NUM) bits wide.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- mode  in  1  LOW = reload parameters, HIGH = calculate
- para_in  in  `PARA_WIDTH  signed parameter word
- para_valid  in  1  para_in is valid this cycle
- para_ready  out  1  loader accepts a word this cycle
- rprelu_beta  out  `PARA_WIDTH x [CHANNEL_NUM-1:0]  signed beta bank
- rprelu_gamma  out  `PARA_WIDTH x [CHANNEL_NUM-1:0]  signed gamma bank
- rprelu_zeta  out  `PARA_WIDTH x [CHANNEL_NUM-1:0]  signed zeta bank
- load_done  out  1  all banks loaded (and checksum passed, when the feature is enabled)
- load_abort  out  1  one-cycle pulse: load interrupted by `mode` going HIGH
- load_err  out  1  checksum mismatch; tied 0 when the feature is disabled

Behaviour:
- Reset: on a clk edge with rst_n==0:
  - state=IDLE, cnt=0.
  - All bank entries = 0.
  - para_ready=0, load_done=0, load_abort=0, load_err=0.
- States: IDLE, LD_BETA, LD_GAMMA, LD_ZETA, [LD_CSUM], DONE.
- IDLE: if mode==0, go to LD_BETA next cycle, with cnt=0 and load_done, load_err and the checksum accumulator cleared. Otherwise stay in IDLE.
- Ready: para_ready is combinational = (state is any LD_*) && mode==0.
- Transfer: a transfer occurs on a clk edge where para_valid && para_ready.
  - para_valid while para_ready==0 is ignored: no write, no counter change.
  - para_valid may stay high across cycles; each accepting cycle is one transfer.
- Word order: CHANNEL_NUM betas (channel 0 first), then CHANNEL_NUM gammas, then CHANNEL_NUM zetas.
- Per transfer in LD_x: bank_x[cnt] <= para_in; cnt <= cnt+1.
  - At cnt==CHANNEL_NUM-1, cnt wraps to 0 and the state advances: LD_BETA→LD_GAMMA→LD_ZETA→DONE, or →LD_CSUM when the feature is enabled.
- Write latency: a written entry appears on its output port the cycle after the transfer edge.
  - Untouched entries hold their value; outputs are direct register outputs.
- Completion: the last zeta transfer moves to DONE and sets load_done=1 on the same edge.
  - DONE holds with para_ready=0 while mode==0.
  - On mode==1 in DONE, go to IDLE; load_done stays 1 through calculate.
  - The next mode==0 in IDLE starts a new load and clears load_done.
- Abort: mode==1 on any edge while in LD_*:
  - state→IDLE, cnt=0, load_abort=1 for exactly one cycle, load_done stays 0.
  - Entries already written keep their new values (partial load); no transfer occurs that edge, since para_ready is 0.
- Simultaneous mode rising with para_valid: no transfer (para_ready is 0), abort takes effect.
- Calculate mode: banks are never written while mode==1.
- Transfer count: a full load is exactly 3*CHANNEL_NUM transfers (+1 with the feature enabled).

Optional Feature:
- Macro: PARA_LOAD_CHECKSUM_EN.
- Defined:
  - An accumulator sums every bank word modulo 2^`PARA_WIDTH.
  - After the last zeta the FSM enters LD_CSUM, accepts one more word and compares it with the sum.
  - Match: DONE with load_done=1, load_err=0.
  - Mismatch: DONE with load_done=0, load_err=1; banks keep the loaded values.
  - load_err clears on the next load start or on reset.
  - Abort in LD_CSUM behaves like any other abort.
- Undefined: no accumulator and no LD_CSUM state; load_err is constant 0; last zeta → DONE.

Test Plan (bench CHANNEL_NUM=4, `PARA_WIDTH=16):
- Reset then mode=0, stream with valid held high: beta 0x0001..0x0004, gamma 0x0010..0x0013, zeta 0xFFF0..0xFFF3 → para_ready high for 12 cycles. beta[3]=0x0004, gamma[0]=0x0010, zeta[2]=0xFFF2. load_done=1 the cycle after the 12th transfer.
- Same stream with para_valid toggling 1/0 every cycle → identical bank contents, and load_done after 23 cycles in LD_*. No write on the invalid cycles.
- mode=1 after 6 transfers → load_abort pulses once, load_done=0, beta[0..3] written, gamma[0..1]=new, gamma[2..3] unchanged. The next mode=0 restarts at beta[0].
- After a completed load, mode=1 with para_valid=1 and para_in=0x7FFF for 10 cycles → para_ready=0, no bank entry changes, load_done stays 1.
- rst_n=0 for one cycle mid-load (after 5 transfers) → all banks 0, load_done=0, state IDLE; a reload starts on the next edge with mode=0.
- PARA_LOAD_CHECKSUM_EN defined: stream as in the first scenario, then checksum word = mod-2^16 sum of the 12 words → load_done=1. Same stream with the checksum word +1 → load_done=0, load_err=1.
